// File: rtl/imm_gen_pipe_pkg.sv
// rtl/imm_gen_pipe_pkg.sv - shared encodings for the pipelined immediate generator
//
// Purpose: format-class encodings, RV opcode[6:2] values, C-extension
// quadrant/funct3 values, buffer state encoding and the per-entry metadata
// record shared by imm_decode_comb and imm_gen_pipe.
// Ports: none (package).

`ifndef INSR_LEN
`define INSR_LEN 32
`endif

package imm_gen_pipe_pkg;

  // Format class reported on fmt_o.
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // 32-bit major opcodes, insr[6:2].
  localparam logic [4:0] OP_LOAD    = 5'b00000;
  localparam logic [4:0] OP_MISCMEM = 5'b00011;
  localparam logic [4:0] OP_OPIMM   = 5'b00100;
  localparam logic [4:0] OP_AUIPC   = 5'b00101;
  localparam logic [4:0] OP_OPIMM32 = 5'b00110;
  localparam logic [4:0] OP_STORE   = 5'b01000;
  localparam logic [4:0] OP_OP      = 5'b01100;
  localparam logic [4:0] OP_LUI     = 5'b01101;
  localparam logic [4:0] OP_OP32    = 5'b01110;
  localparam logic [4:0] OP_BRANCH  = 5'b11000;
  localparam logic [4:0] OP_JALR    = 5'b11001;
  localparam logic [4:0] OP_JAL     = 5'b11011;
  localparam logic [4:0] OP_SYSTEM  = 5'b11100;

  // Compressed quadrants, insr[1:0].
  localparam logic [1:0] CQ0 = 2'b00;
  localparam logic [1:0] CQ1 = 2'b01;

  // Compressed funct3, insr[15:13], grouped by quadrant.
  localparam logic [2:0] C0_ADDI4SPN = 3'b000;
  localparam logic [2:0] C0_LW       = 3'b010;
  localparam logic [2:0] C0_SW       = 3'b110;

  localparam logic [2:0] C1_ADDI     = 3'b000;
  localparam logic [2:0] C1_JAL      = 3'b001;
  localparam logic [2:0] C1_LI       = 3'b010;
  localparam logic [2:0] C1_LUI      = 3'b011;
  localparam logic [2:0] C1_MISC_ALU = 3'b100;
  localparam logic [2:0] C1_J        = 3'b101;
  localparam logic [2:0] C1_BEQZ     = 3'b110;
  localparam logic [2:0] C1_BNEZ     = 3'b111;

  localparam logic [2:0] C2_SLLI     = 3'b000;
  localparam logic [2:0] C2_LWSP     = 3'b010;
  localparam logic [2:0] C2_SWSP     = 3'b110;

  // Output buffer occupancy.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  typedef struct packed {
    fmt_e fmt;
    logic is_c;
    logic illegal;
  } meta_t;

endpackage

// File: rtl/imm_decode_comb.sv
// rtl/imm_decode_comb.sv - combinational RV immediate / format decoder
//
// Purpose: map one raw instruction to its extended immediate, format class,
// compressed flag and illegal flag.
// Ports:
//   insr     in  32    raw instruction (16-bit ops in [15:0])
//   imm      out XLEN  extended immediate (0 for R-type and illegal)
//   fmt      out 3     format class
//   is_c     out 1     instruction is a 16-bit encoding
//   illegal  out 1     encoding not recognised

module imm_decode_comb
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int SUPPORT_C = 1
) (
  input  logic [`INSR_LEN-1:0] insr,
  output logic [XLEN-1:0]      imm,
  output fmt_e                 fmt,
  output logic                 is_c,
  output logic                 illegal
);

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] c_simm6, c_uimm6, c_addi4spn, c_lw, c_lwsp, c_swsp;
  logic [XLEN-1:0] c_addi16sp, c_lui, c_j, c_b;
  logic [2:0]      c_f3;

  assign c_f3 = insr[15:13];

  // 32-bit scatters, sign bit always insr[31].
  assign imm_i = {{(XLEN-12){insr[31]}}, insr[31:20]};
  assign imm_s = {{(XLEN-12){insr[31]}}, insr[31:25], insr[11:7]};
  assign imm_b = {{(XLEN-13){insr[31]}}, insr[31], insr[7], insr[30:25], insr[11:8], 1'b0};
  assign imm_u = {{(XLEN-31){insr[31]}}, insr[30:12], 12'b0};
  assign imm_j = {{(XLEN-21){insr[31]}}, insr[31], insr[19:12], insr[20], insr[30:21], 1'b0};

  // 16-bit scatters; signed forms extend from insr[12].
  assign c_simm6    = {{(XLEN-6){insr[12]}}, insr[12], insr[6:2]};
  assign c_uimm6    = {{(XLEN-6){1'b0}}, insr[12], insr[6:2]};
  assign c_addi4spn = {{(XLEN-10){1'b0}}, insr[10:7], insr[12:11], insr[5], insr[6], 2'b00};
  assign c_lw       = {{(XLEN-7){1'b0}}, insr[5], insr[12:10], insr[6], 2'b00};
  assign c_lwsp     = {{(XLEN-8){1'b0}}, insr[3:2], insr[12], insr[6:4], 2'b00};
  assign c_swsp     = {{(XLEN-8){1'b0}}, insr[8:7], insr[12:9], 2'b00};
  assign c_addi16sp = {{(XLEN-10){insr[12]}}, insr[12], insr[4:3], insr[5], insr[2], insr[6], 4'b0};
  assign c_lui      = {{(XLEN-18){insr[12]}}, insr[12], insr[6:2], 12'b0};
  assign c_j        = {{(XLEN-12){insr[12]}}, insr[12], insr[8], insr[10:9], insr[6], insr[7],
                       insr[2], insr[11], insr[5:3], 1'b0};
  assign c_b        = {{(XLEN-9){insr[12]}}, insr[12], insr[6:5], insr[2], insr[11:10],
                       insr[4:3], 1'b0};

  always_comb begin
    imm     = '0;
    fmt     = FMT_R;
    is_c    = 1'b0;
    illegal = 1'b0;
    if (insr[1:0] == 2'b11) begin
      case (insr[6:2])
        OP_LUI, OP_AUIPC: begin imm = imm_u; fmt = FMT_U; end
        OP_JAL:           begin imm = imm_j; fmt = FMT_J; end
        OP_JALR, OP_LOAD, OP_OPIMM, OP_MISCMEM, OP_SYSTEM: begin
          imm = imm_i; fmt = FMT_I;
        end
        OP_OPIMM32: begin
          if (XLEN == 64) begin imm = imm_i; fmt = FMT_I; end
          else illegal = 1'b1;
        end
        OP_STORE:  begin imm = imm_s; fmt = FMT_S; end
        OP_BRANCH: begin imm = imm_b; fmt = FMT_B; end
        OP_OP:     fmt = FMT_R;
        OP_OP32:   illegal = (XLEN != 64);
        default:   illegal = 1'b1;
      endcase
    end else begin
      is_c = 1'b1;
      if (SUPPORT_C == 0 || insr[15:0] == 16'h0000) begin
        illegal = 1'b1;
      end else begin
        case (insr[1:0])
          CQ0: begin
            case (c_f3)
              C0_ADDI4SPN: begin imm = c_addi4spn; fmt = FMT_I; end
              C0_LW:       begin imm = c_lw;       fmt = FMT_I; end
              C0_SW:       begin imm = c_lw;       fmt = FMT_S; end
              default:     fmt = FMT_R;
            endcase
          end
          CQ1: begin
            case (c_f3)
              C1_ADDI, C1_LI: begin imm = c_simm6; fmt = FMT_I; end
              // funct3 001 is C.ADDIW on RV64, C.JAL on RV32.
              C1_JAL: begin
                if (XLEN == 64) begin imm = c_simm6; fmt = FMT_I; end
                else begin imm = c_j; fmt = FMT_J; end
              end
              C1_LUI: begin
                if (insr[11:7] == 5'd2) begin imm = c_addi16sp; fmt = FMT_I; end
                else begin imm = c_lui; fmt = FMT_U; end
              end
              C1_MISC_ALU: begin
                case (insr[11:10])
                  2'b00, 2'b01: begin imm = c_uimm6; fmt = FMT_I; end
                  2'b10:        begin imm = c_simm6; fmt = FMT_I; end
                  default:      fmt = FMT_R;
                endcase
              end
              C1_J:            begin imm = c_j; fmt = FMT_J; end
              C1_BEQZ, C1_BNEZ: begin imm = c_b; fmt = FMT_B; end
              default:         fmt = FMT_R;
            endcase
          end
          default: begin
            case (c_f3)
              C2_SLLI: begin imm = c_uimm6; fmt = FMT_I; end
              C2_LWSP: begin imm = c_lwsp;  fmt = FMT_I; end
              C2_SWSP: begin imm = c_swsp;  fmt = FMT_S; end
              default: fmt = FMT_R;
            endcase
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined immediate generator with 2-entry output buffer
//
// Purpose: decode one instruction per cycle and hold results in a 2-entry
// FIFO so the producer runs at full rate under consumer backpressure.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   in_valid_i / in_ready_o  input handshake
//   insr_i [31:0]            raw instruction
//   flush_i                  drop all buffered entries and the current input
//   out_valid_o / out_ready_i output handshake
//   imm_o [XLEN-1:0], fmt_o [2:0], is_c_o, illegal_o  head entry fields

module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int SUPPORT_C = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [`INSR_LEN-1:0] insr_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [XLEN-1:0]      imm_o,
  output logic [2:0]           fmt_o,
  output logic                 is_c_o,
  output logic                 illegal_o
);

  buf_state_e      state_q, state_d;
  logic [XLEN-1:0] imm_mem  [2];
  meta_t           meta_mem [2];
  logic            wr_ptr_q, rd_ptr_q;
  logic            push, pop;

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_is_c, dec_illegal;
  meta_t           dec_meta;

  imm_decode_comb #(
    .XLEN      (XLEN),
    .SUPPORT_C (SUPPORT_C)
  ) u_decode (
    .insr    (insr_i),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .is_c    (dec_is_c),
    .illegal (dec_illegal)
  );

  assign dec_meta = '{fmt: dec_fmt, is_c: dec_is_c, illegal: dec_illegal};

  // Ready depends on registered state only (plus reset), never on out_ready_i.
  assign in_ready_o  = !rst_i && (state_q != ST_FULL);
  assign out_valid_o = (state_q != ST_EMPTY);
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (push) state_d = ST_ONE;
        ST_ONE: begin
          if (push && !pop)      state_d = ST_FULL;
          else if (pop && !push) state_d = ST_EMPTY;
        end
        ST_FULL:  if (pop) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        imm_mem[i]  <= '0;
        meta_mem[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (flush_i) begin
        // Re-align pointers so the next push becomes the head directly.
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          imm_mem[wr_ptr_q]  <= dec_imm;
          meta_mem[wr_ptr_q] <= dec_meta;
          wr_ptr_q           <= !wr_ptr_q;
        end
        if (pop) rd_ptr_q <= !rd_ptr_q;
      end
    end
  end

  assign imm_o     = imm_mem[rd_ptr_q];
  assign fmt_o     = meta_mem[rd_ptr_q].fmt;
  assign is_c_o    = meta_mem[rd_ptr_q].is_c;
  assign illegal_o = meta_mem[rd_ptr_q].illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed self-checking bench for imm_gen_pipe

module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] insr;

  // a: XLEN=32 with C, b: XLEN=64 with C, c: XLEN=32 without C
  logic        a_ready, a_valid, a_is_c, a_ill;
  logic [31:0] a_imm;
  logic [2:0]  a_fmt;
  logic        b_ready, b_valid, b_is_c, b_ill;
  logic [63:0] b_imm;
  logic [2:0]  b_fmt;
  logic        c_ready, c_valid, c_is_c, c_ill;
  logic [31:0] c_imm;
  logic [2:0]  c_fmt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SUPPORT_C(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(a_ready),
    .insr_i(insr), .flush_i(flush), .out_valid_o(a_valid), .out_ready_i(out_ready),
    .imm_o(a_imm), .fmt_o(a_fmt), .is_c_o(a_is_c), .illegal_o(a_ill)
  );

  imm_gen_pipe #(.XLEN(64), .SUPPORT_C(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(b_ready),
    .insr_i(insr), .flush_i(flush), .out_valid_o(b_valid), .out_ready_i(out_ready),
    .imm_o(b_imm), .fmt_o(b_fmt), .is_c_o(b_is_c), .illegal_o(b_ill)
  );

  imm_gen_pipe #(.XLEN(32), .SUPPORT_C(0)) dut_c (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(c_ready),
    .insr_i(insr), .flush_i(flush), .out_valid_o(c_valid), .out_ready_i(out_ready),
    .imm_o(c_imm), .fmt_o(c_fmt), .is_c_o(c_is_c), .illegal_o(c_ill)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    in_valid = 1'b1;
    insr     = w;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; insr = '0;
    step(); step();
    chk("rst_valid", a_valid, 0);
    chk("rst_ready", a_ready, 0);
    chk("rst_imm", a_imm, 0);
    chk("rst_fmt", a_fmt, 0);
    chk("rst_is_c", a_is_c, 0);
    chk("rst_ill", a_ill, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", a_ready, 1);

    send(32'hFFF00093);
    chk("addi_valid", a_valid, 1);
    chk("addi_imm", a_imm, 32'hFFFF_FFFF);
    chk("addi_fmt", a_fmt, 1);
    chk("addi_ill", a_ill, 0);
    chk("addi_is_c", a_is_c, 0);
    chk("addi_imm64", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);

    send(32'h123450B7);
    chk("lui_valid", a_valid, 1);
    chk("lui_imm", a_imm, 32'h1234_5000);
    chk("lui_fmt", a_fmt, 4);

    send(32'h800000B7);
    chk("lui_neg_imm32", a_imm, 32'h8000_0000);
    chk("lui_neg_imm64", b_imm, 64'hFFFF_FFFF_8000_0000);

    send(32'hFE000EE3);
    chk("beq_imm", a_imm, 32'hFFFF_FFFC);
    chk("beq_fmt", a_fmt, 3);

    send(32'hFE112E23);
    chk("sw_imm", a_imm, 32'hFFFF_FFFC);
    chk("sw_fmt", a_fmt, 2);

    send(32'h0040006F);
    chk("jal_imm", a_imm, 32'h4);
    chk("jal_fmt", a_fmt, 5);

    send(32'h0000007F);
    chk("op7f_ill", a_ill, 1);
    chk("op7f_imm", a_imm, 0);
    chk("op7f_fmt", a_fmt, 0);

    send(32'h0000003B);
    chk("op32_ill_rv32", a_ill, 1);
    chk("op32_ill_rv64", b_ill, 0);
    chk("op32_fmt_rv64", b_fmt, 0);

    send(32'h000050FD);
    chk("cli_imm", a_imm, 32'hFFFF_FFFF);
    chk("cli_fmt", a_fmt, 1);
    chk("cli_is_c", a_is_c, 1);
    chk("cli_ill", a_ill, 0);
    chk("cli_is_c64", b_is_c, 1);
    chk("cli_noc_ill", c_ill, 1);
    chk("cli_noc_imm", c_imm, 0);
    chk("cli_noc_is_c", c_is_c, 1);

    send(32'hABCD50FD);
    chk("cli_upper_ignored", a_imm, 32'hFFFF_FFFF);

    send(32'h00006085);
    chk("clui_imm", a_imm, 32'h0000_1000);
    chk("clui_fmt", a_fmt, 4);

    send(32'h00000000);
    chk("c0000_ill", a_ill, 1);
    chk("c0000_is_c", a_is_c, 1);

    step();
    chk("drain_valid", a_valid, 0);

    // Backpressure: A,B fill the buffer, C must wait.
    out_ready = 1'b0;
    in_valid = 1'b1; insr = 32'h00100093; step();
    chk("bp_ready_a", a_ready, 1);
    insr = 32'h00200093; step();
    chk("bp_ready_b", a_ready, 0);
    insr = 32'h00300093; step();
    chk("bp_hold_imm", a_imm, 1);
    chk("bp_hold_ready", a_ready, 0);
    out_ready = 1'b1; step();
    chk("bp_b_valid", a_valid, 1);
    chk("bp_b_imm", a_imm, 2);
    step();
    in_valid = 1'b0;
    chk("bp_c_valid", a_valid, 1);
    chk("bp_c_imm", a_imm, 3);
    step();
    chk("bp_empty", a_valid, 0);

    // Flush while FULL with a competing input.
    out_ready = 1'b0;
    in_valid = 1'b1; insr = 32'h00500093; step();
    insr = 32'h00600093; step();
    chk("pre_flush_ready", a_ready, 0);
    insr = 32'h00700093; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_full_valid", a_valid, 0);
    chk("flush_full_ready", a_ready, 1);
    step();
    chk("flush_full_no_ghost", a_valid, 0);

    // Flush while ONE with a competing input that would otherwise be accepted.
    in_valid = 1'b1; insr = 32'h00800093; step();
    insr = 32'h00900093; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_one_valid", a_valid, 0);
    out_ready = 1'b1;
    send(32'h00A00093);
    chk("post_flush_valid", a_valid, 1);
    chk("post_flush_imm", a_imm, 10);
    step();

    // Reset mid-stream.
    out_ready = 1'b0;
    send(32'h00B00093);
    rst = 1'b1; step();
    chk("rst_mid_valid", a_valid, 0);
    chk("rst_mid_imm", a_imm, 0);
    rst = 1'b0; step();
    chk("rst_mid_no_ghost", a_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the ID stage. Accepts one raw instruction per cycle through a valid/ready handshake and emits the sign-/zero-extended immediate, its format class and a compressed flag one cycle later. Illegal encodings are flagged rather than silently mapped to zero. A 2-entry output buffer gives full throughput under backpressure, and a flush input kills in-flight work on branch redirect.

## Interface
- XLEN, 32: immediate width; 32 or 64.
- SUPPORT_C, 1: 1 = decode RV C-extension (16-bit) encodings; 0 = treat them as illegal.

- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  insr_i holds an instruction.
- in_ready_o  out  1  block can accept this cycle.
- insr_i  in  32  raw instruction; a 16-bit op occupies [15:0], and [31:16] are ignored.
- flush_i  in  1  discard all buffered entries and the current input.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  consumer takes head this cycle.
- imm_o  out  XLEN  immediate of head entry.
- fmt_o  out  3  format class of head: R=0, I=1, S=2, B=3, U=4, J=5.
- is_c_o  out  1  head came from a 16-bit encoding.
- illegal_o  out  1  head opcode is not recognised.

## Operation
- Push when in_valid_i && in_ready_o && !flush_i. Pop when out_valid_o && out_ready_i.
- 32-bit decode applies when insr_i[1:0]==2'b11. It uses opcode[6:2]:
  - 01101, 00101 → U: {insr[31:12],12'b0}, sign-extended from bit 31 to XLEN.
  - 11011 → J.
  - 11001, 00000, 00100, 00011, 11100 → I. 00110 is also I when XLEN==64; it is illegal when XLEN==32.
  - 01000 → S. 11000 → B.
  - 01100 → R, imm 0. 01110 is R when XLEN==64; it is illegal otherwise.
  - Any other opcode → illegal, imm 0, fmt R.
- I/S/B/J immediates use standard RV bit scatter and are sign-extended from insr[31].
- 16-bit decode applies when insr_i[1:0]!=2'b11 and SUPPORT_C==1:
  - C.ADDI4SPN, C.LW/SW, C.LWSP/SWSP, C.SLLI/SRLI/SRAI → zero-extended uimm. fmt is I, except S for the stores.
  - C.ADDI/LI/ANDI → 6-bit signed, fmt I.
  - C.ADDI16SP → signed nzimm<<4, fmt I.
  - C.LUI → signed nzimm<<12, fmt U.
  - C.J/JAL → signed 12-bit offset, fmt J.
  - C.BEQZ/BNEZ → signed 9-bit offset, fmt B.
  - Remaining valid quadrant ops (MV/ADD/JR/JALR/EBREAK/ALU) → fmt R, imm 0.
  - insr_i[15:0]==16'h0000 → illegal.
- 16-bit encoding with SUPPORT_C==0 → illegal=1, imm 0, is_c 1.
- Buffer: 2-entry FIFO, states EMPTY(0), ONE(1), FULL(2).
  - EMPTY: push → ONE.
  - ONE: push&&!pop → FULL; pop&&!push → EMPTY; push&&pop → ONE, new entry becomes head next cycle.
  - FULL: pop → ONE. No push, since in_ready_o=0.
  - flush_i from any state → EMPTY. Flush takes priority over push and pop.

## Timing
- Latency: instruction pushed at edge N is visible on the outputs after edge N (out_valid_o high in cycle N+1).
- Throughput: 1/cycle while out_ready_i is held high.
- in_ready_o = (state!=FULL). It is registered-state-derived only, with no combinational path from out_ready_i.
- Outputs are driven from the head entry registers and are stable while out_valid_o && !out_ready_i.
- Reset values: state EMPTY, out_valid_o 0, in_ready_o 0 during rst_i then 1, imm_o 0, fmt_o 0, is_c_o 0, illegal_o 0.
- Reset or flush mid-stream: all entries are lost, and no partial entry reappears afterwards.
- Per-entry payload fields update only on push. Head output values are don't-care when out_valid_o=0, except on reset, where they are 0.

## Structure
- Shared header/package: the fmt_o encodings (FMT_R..FMT_J), RV opcode[6:2] constants, the C quadrant/funct3 constants, and the existing INSR_LEN macro.
- Sub-module imm_decode_comb: purely combinational; insr → {imm, fmt, is_c, illegal}; parametrised on XLEN and SUPPORT_C.
- imm_gen_pipe holds the handshake, the 2-entry storage and the state counter.

## Test plan
- addi x1,x0,-1 (0xFFF00093) pushed with out_ready_i=1 → next cycle imm_o=0xFFFFFFFF, fmt I, illegal 0.
- lui 0x12345 (0x123450B7) → 0x12345000, fmt U. With XLEN=64, 0x800000B7 → 0xFFFFFFFF80000000.
- beq x0,x0,-4 (0xFE000EE3) → imm 0xFFFFFFFC, fmt B. Opcode 0x7F → illegal 1, imm 0.
- Backpressure: out_ready_i=0, push A,B,C back-to-back → in_ready_o low after B, C held. Then raise out_ready_i → A,B,C emerge in order, with no loss or duplication.
- FULL + flush_i with in_valid_i=1 the same cycle → next cycle out_valid_o=0, in_ready_o=1, and the input was not accepted.
- c.li x1,-1 (0x50FD) → imm 0xFFFFFFFF, fmt I, is_c 1. With SUPPORT_C=0 → illegal 1, imm 0. 0x0000 → illegal 1.
